ring_sequence_checker: RTL and testbench
========================================

// Module: ring_sequence_checker
// PURPOSE
//   Consumes the N-bit one-hot vector produced by a ring counter, one sample per CE edge.
//   Checks that exactly one bit is set and that the set bit rotates by one position each sample.
//   Outputs the binary phase index, a lock indication and a sticky error flag.
//   Counts full ring revolutions. Sits directly downstream of the ring counter, ahead of LED/status logic.
// PARAMETERS
//   N         7   ring width in bits; N >= 2
//   REV_W     16  width of the revolution counter
//   LOCK_CNT  2   consecutive correct steps needed to lock; range 1..15
// PORTS
//   CLK     in   1                sole clock, rising edge
//   RESET   in   1                asynchronous reset, active-high
//   I       in   N                ring vector; bit 0 is phase 0
//   CE      in   1                sample enable; I is evaluated only on CE=1 edges
//   CLR     in   1                synchronous clear of ERR and REVS; acts regardless of CE
//   INDEX   out  $clog2(N)        position of the set bit in the last valid sample
//   VALID   out  1                last sample was exactly one-hot
//   LOCKED  out  1                sequence tracked and correct
//   ERR     out  1                sticky: a step error occurred while LOCKED
//   REVS    out  REV_W            revolution count
// BEHAVIOUR
//   - RESET=1 clears immediately, without waiting for CLK:
//       INDEX=0, VALID=0, LOCKED=0, ERR=0, REVS=0, prev=0, cnt=0, state=SYNC.
//   - All outputs are registered. Latency is 1 cycle: a sample on edge k is reflected after edge k.
//   - CE=0: all state and outputs hold. CLR still acts.
//   - onehot(I): popcount(I)==1. All-zero and multi-bit vectors are invalid.
//   - VALID <= onehot(I) on every CE edge.
//   - INDEX updates only on valid samples; otherwise it holds.
//   - Correct step (ok): onehot(I) && I == rotl1(prev).
//       rotl1 moves bit i to bit i+1, and bit N-1 to bit 0.
//   - prev <= I on every valid sample.
//   - State machine, evaluated on CE edges:
//       SYNC:   valid -> TRACK, cnt=0. Invalid -> stay in SYNC.
//       TRACK:  ok -> cnt++; when cnt reaches LOCK_CNT -> LOCKED.
//               Valid but not ok -> TRACK, cnt=0. Invalid -> SYNC.
//       LOCKED: ok -> stay. Not ok -> FAULT and set ERR=1.
//       FAULT:  valid -> TRACK, cnt=0. Invalid -> stay in FAULT.
//   - LOCKED output = (state==LOCKED).
//   - Revolution: in LOCKED, an ok step with I[0]=1 and prev[N-1]=1 increments REVS.
//       REVS wraps modulo 2^REV_W.
//   - CLR=1 on an edge: ERR<=0 and REVS<=0. Clear wins over a simultaneous set or increment.
//   - ERR is not cleared by relock. Only CLR or RESET clears it.
//   - RESET mid-stream: returns to SYNC. A full relock (LOCK_CNT+1 valid samples) is required.
// CONFIGURATION
//   RING_CHECK_SAT_EN
//     defined:   REVS saturates at all-ones and no longer increments.
//     undefined: REVS wraps to 0 after all-ones.
//   The macro does not affect any other output.
// TESTING  (N=7, LOCK_CNT=2, CE=1 unless stated)
//   1. Release RESET; drive I = 0000001, 0000010, 0000100 on 3 edges.
//      -> LOCKED=1 after 3rd edge; INDEX=2; VALID=1.
//   2. While locked, run 3 full rotations through 1000000->0000001.
//      -> REVS=3; ERR=0.
//   3. While locked, drive I=0000110.
//      -> VALID=0, LOCKED=0, ERR=1, INDEX held.
//      Then 3 correct samples -> LOCKED=1, ERR still 1.
//   4. Assert CLR on the same edge as a wrap step.
//      -> REVS=0, ERR=0.
//      Separately, CE=0 for 5 cycles with I changing -> no output changes.
//   5. Assert RESET asynchronously mid-cycle while locked.
//      -> all outputs 0 before the next CLK edge; relock takes 3 samples.
//   6. REV_W=2, locked, 5 wraps.
//      -> REVS=3 with RING_CHECK_SAT_EN defined; REVS=1 without it.

Source files
------------

// File: rtl/ring_sequence_checker.sv
`default_nettype none
// ============================================================================
// Module      : ring_sequence_checker
// Description : Monitors the one-hot output of an N-bit ring counter, one
//               sample per CE edge. Reports the phase index of the set bit,
//               whether the last sample was one-hot, whether the rotation
//               sequence is locked, a sticky step-error flag and a count of
//               completed ring revolutions.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N         ring width in bits (N >= 2)
//   REV_W     width of the revolution counter
//   LOCK_CNT  consecutive correct steps required to lock (1..15)
// Ports
//   CLK     in   1              clock, rising edge
//   RESET   in   1              asynchronous reset, active-high
//   I       in   N              ring vector, bit 0 is phase 0
//   CE      in   1              sample enable
//   CLR     in   1              synchronous clear of ERR and REVS (ignores CE)
//   INDEX   out  $clog2(N)      phase index of the last valid sample
//   VALID   out  1              last sample was exactly one-hot
//   LOCKED  out  1              sequence tracked and correct
//   ERR     out  1              sticky: step error seen while locked
//   REVS    out  REV_W          revolution count
// Configuration macro
//   RING_CHECK_SAT_EN  defined: REVS saturates at all-ones.
//                      undefined: REVS wraps modulo 2^REV_W.
// ============================================================================
module ring_sequence_checker #(
  parameter int N        = 7,
  parameter int REV_W    = 16,
  parameter int LOCK_CNT = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [N-1:0]         I,
  input  logic                 CE,
  input  logic                 CLR,
  output logic [$clog2(N)-1:0] INDEX,
  output logic                 VALID,
  output logic                 LOCKED,
  output logic                 ERR,
  output logic [REV_W-1:0]     REVS
);

  localparam int IDX_W = $clog2(N);
  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_CNT);

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  state_t            state;
  logic [N-1:0]      prev;
  logic [3:0]        cnt;

  logic              sample_valid;
  logic [IDX_W-1:0]  sample_idx;
  logic [N-1:0]      prev_rot;
  logic              step_ok;
  logic              rev_step;
  logic [REV_W-1:0]  revs_inc;

  assign sample_valid = ($countones(I) == 1);

  // Priority encoder; only consumed when the sample is one-hot.
  always_comb begin
    sample_idx = '0;
    for (int b = 0; b < N; b++) begin
      if (I[b]) sample_idx = IDX_W'(b);
    end
  end

  assign prev_rot = {prev[N-2:0], prev[N-1]};
  assign step_ok  = sample_valid && (I == prev_rot);
  // A revolution completes on the step from phase N-1 back to phase 0.
  assign rev_step = (state == ST_LOCKED) && step_ok && I[0] && prev[N-1];

`ifdef RING_CHECK_SAT_EN
  assign revs_inc = (&REVS) ? REVS : REVS + REV_W'(1);
`else
  assign revs_inc = REVS + REV_W'(1);
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= ST_SYNC;
      prev   <= '0;
      cnt    <= '0;
      INDEX  <= '0;
      VALID  <= 1'b0;
      LOCKED <= 1'b0;
      ERR    <= 1'b0;
      REVS   <= '0;
    end else begin
      if (CE) begin
        VALID <= sample_valid;
        if (sample_valid) begin
          INDEX <= sample_idx;
          prev  <= I;
        end

        case (state)
          ST_SYNC: begin
            if (sample_valid) begin
              state <= ST_TRACK;
              cnt   <= '0;
            end
          end
          ST_TRACK: begin
            if (step_ok) begin
              if (cnt + 4'd1 == LOCK_TARGET) begin
                state  <= ST_LOCKED;
                LOCKED <= 1'b1;
                cnt    <= '0;
              end else begin
                cnt <= cnt + 4'd1;
              end
            end else if (sample_valid) begin
              cnt <= '0;
            end else begin
              state <= ST_SYNC;
            end
          end
          ST_LOCKED: begin
            if (!step_ok) begin
              state  <= ST_FAULT;
              LOCKED <= 1'b0;
              ERR    <= 1'b1;
            end
          end
          ST_FAULT: begin
            if (sample_valid) begin
              state <= ST_TRACK;
              cnt   <= '0;
            end
          end
          default: begin
            state  <= ST_SYNC;
            LOCKED <= 1'b0;
          end
        endcase

        if (rev_step) REVS <= revs_inc;
      end

      // Clear is last so it wins over a same-edge error or increment.
      if (CLR) begin
        ERR  <= 1'b0;
        REVS <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ring_sequence_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_ring_sequence_checker
// Description : Self-checking bench for ring_sequence_checker. Directed
//               scenarios followed by randomized stimulus, compared each cycle
//               against an index-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_sequence_checker;

  localparam int N        = 7;
  localparam int REV_W    = 3;
  localparam int LOCK_CNT = 2;
  localparam int IW       = $clog2(N);

  logic          CLK = 1'b0;
  logic          RESET;
  logic [N-1:0]  I;
  logic          CE;
  logic          CLR;
  logic [IW-1:0] INDEX;
  logic          VALID;
  logic          LOCKED;
  logic          ERR;
  logic [REV_W-1:0] REVS;

  int n_checks = 0;
  int n_fail   = 0;

  ring_sequence_checker #(.N(N), .REV_W(REV_W), .LOCK_CNT(LOCK_CNT)) dut (
    .CLK(CLK), .RESET(RESET), .I(I), .CE(CE), .CLR(CLR),
    .INDEX(INDEX), .VALID(VALID), .LOCKED(LOCKED), .ERR(ERR), .REVS(REVS)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model (phase indices, not bit vectors) -------
  // mode: 0 = searching, 1 = tracking, 2 = locked, 3 = faulted
  int m_mode, m_run, m_prev, m_index, m_valid, m_err, m_revs;

  function automatic logic [N-1:0] oh(input int k);
    logic [N-1:0] one;
    one = 1;
    return one << k;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_run = 0; m_prev = -1; m_index = 0;
    m_valid = 0; m_err = 0; m_revs = 0;
  endtask

  task automatic model_step(input bit ce, input bit clr, input logic [N-1:0] vec);
    int ones, pos;
    bit v, ok;
    if (ce) begin
      ones = 0; pos = 0;
      for (int b = 0; b < N; b++) if (vec[b]) begin ones++; pos = b; end
      v  = (ones == 1);
      ok = v && (m_prev >= 0) && (pos == (m_prev + 1) % N);
      if (m_mode == 2 && ok && pos == 0) begin
`ifdef RING_CHECK_SAT_EN
        if (m_revs < (1 << REV_W) - 1) m_revs++;
`else
        m_revs = (m_revs + 1) % (1 << REV_W);
`endif
      end
      case (m_mode)
        0: if (v) begin m_mode = 1; m_run = 0; end
        1: begin
          if (ok) begin
            m_run++;
            if (m_run >= LOCK_CNT) m_mode = 2;
          end else if (v) m_run = 0;
          else m_mode = 0;
        end
        2: if (!ok) begin m_mode = 3; m_err = 1; end
        default: if (v) begin m_mode = 1; m_run = 0; end
      endcase
      m_valid = v;
      if (v) begin m_index = pos; m_prev = pos; end
    end
    if (clr) begin m_err = 0; m_revs = 0; end
  endtask

  // ---------------- checking ----------------------------------------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string where);
    check_val({where, ".INDEX"},  32'(INDEX),  32'(m_index));
    check_val({where, ".VALID"},  32'(VALID),  32'(m_valid));
    check_val({where, ".LOCKED"}, 32'(LOCKED), 32'(m_mode == 2));
    check_val({where, ".ERR"},    32'(ERR),    32'(m_err));
    check_val({where, ".REVS"},   32'(REVS),   32'(m_revs));
  endtask

  // Inputs change just after a falling edge; outputs are sampled on the next one.
  task automatic step(input bit ce, input bit clr, input logic [N-1:0] vec, input string where);
    CE = ce; CLR = clr; I = vec;
    @(posedge CLK);
    model_step(ce, clr, vec);
    @(negedge CLK);
    check_all(where);
  endtask

  task automatic async_reset(input string where);
    #2 RESET = 1'b1;
    model_reset();
    #1 check_all(where);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    int a, r, expect_revs;
    logic [N-1:0] vec;

    RESET = 1'b1; CE = 1'b0; CLR = 1'b0; I = '0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    check_all("reset");
    RESET = 1'b0;

    // Lock on three consecutive phases.
    step(1, 0, oh(0), "lock0");
    step(1, 0, oh(1), "lock1");
    step(1, 0, oh(2), "lock2");
    check_val("t1.LOCKED", 32'(LOCKED), 32'd1);
    check_val("t1.INDEX",  32'(INDEX),  32'd2);

    // Three full revolutions while locked.
    for (int k = 3; k < 24; k++) step(1, 0, oh(k % N), "rot");
    check_val("t2.REVS", 32'(REVS), 32'd3);
    check_val("t2.ERR",  32'(ERR),  32'd0);

    // Multi-bit sample while locked, then relock.
    step(1, 0, 7'b0000110, "bad");
    check_val("t3.INDEX", 32'(INDEX), 32'd2);
    check_val("t3.ERR",   32'(ERR),   32'd1);
    step(1, 0, oh(3), "relock0");
    step(1, 0, oh(4), "relock1");
    step(1, 0, oh(5), "relock2");
    check_val("t3.LOCKED", 32'(LOCKED), 32'd1);
    check_val("t3.ERR2",   32'(ERR),    32'd1);

    // Clear on the same edge as a revolution step.
    step(1, 0, oh(6), "pre_wrap");
    step(1, 1, oh(0), "clr_wrap");
    check_val("t4.REVS", 32'(REVS), 32'd0);
    check_val("t4.ERR",  32'(ERR),  32'd0);

    // CE low: inputs wander, everything holds.
    for (int k = 0; k < 5; k++) step(0, 0, N'($urandom), "ce_hold");
    check_val("t4.hold_INDEX", 32'(INDEX), 32'd0);

    // Asynchronous reset while locked, then relock.
    step(1, 0, oh(1), "pre_rst");
    async_reset("async_rst");
    check_val("t5.LOCKED", 32'(LOCKED), 32'd0);
    step(1, 0, oh(2), "rl0");
    step(1, 0, oh(3), "rl1");
    check_val("t5.not_yet", 32'(LOCKED), 32'd0);
    step(1, 0, oh(4), "rl2");
    check_val("t5.LOCKED2", 32'(LOCKED), 32'd1);

    // Ten revolutions on a 3-bit counter: wrap or saturate.
    for (int k = 5; k < 75; k++) step(1, 0, oh(k % N), "wrap");
`ifdef RING_CHECK_SAT_EN
    expect_revs = 7;
`else
    expect_revs = 2;
`endif
    check_val("t6.REVS", 32'(REVS), 32'(expect_revs));

    // Randomized traffic.
    for (int c = 0; c < 800; c++) begin
      r = int'($urandom_range(0, 99));
      if (r < 1) begin
        async_reset("rnd_rst");
      end else begin
        a = int'($urandom_range(0, 99));
        if (a < 80)      vec = oh((m_index + 1) % N);
        else if (a < 88) vec = oh(int'($urandom_range(0, N - 1)));
        else if (a < 94) vec = '0;
        else begin
          a   = int'($urandom_range(0, N - 1));
          vec = oh(a) | oh((a + 1 + int'($urandom_range(0, N - 2))) % N);
        end
        step($urandom_range(0, 99) >= 10, $urandom_range(0, 99) < 3, vec, "rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
